// File: rtl/uart_mul_engine_pkg.sv
// Shared types and helpers for the UART byte-stream multiply engine.
// Holds the FSM state encoding, byte/counter sizing helpers and the UART byte width.
package mul_uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_MUL,
    ST_TX,
    ST_TX_GAP,
    ST_DONE
  } state_t;

  // Bytes in one frame: two operands of op_bytes each.
  function automatic int byte_count(input int op_bytes);
    return 2 * op_bytes;
  endfunction

  // Counter width for a limit, never below one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/uart_mul_engine_if.sv
// UART byte handshake between the multiply engine (master) and the UART block (slave).
interface uart_mul_engine_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (input rx_data, rx_valid, tx_ready, output tx_data, tx_start);
  modport slave  (output rx_data, rx_valid, tx_ready, input tx_data, tx_start);
endinterface

// File: rtl/uart_mul_engine_seq_shift_add_mul.sv
// Unsigned W x W shift-add multiplier, one multiplier bit per cycle.
// done pulses with p valid W cycles after an accepted start; start is ignored while running.
module seq_shift_add_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] p
);
  localparam int CW = $clog2(W + 1);

  logic [CW-1:0]  cnt;
  logic           run;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] addend;
  logic [W-1:0]   mplier;

  assign addend = mplier[0] ? mcand : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      run    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      done   <= 1'b0;
      p      <= '0;
    end else begin
      done <= 1'b0;
      if (run) begin
        acc    <= acc + addend;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        // Last partial product is folded straight into p so done lands on cycle W.
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
          p    <= acc + addend;
        end
      end else if (start) begin
        acc    <= '0;
        mcand  <= {{W{1'b0}}, a};
        mplier <= b;
        cnt    <= CW'(W);
        run    <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_mul_engine.sv
// Collects two OP_BYTES operands from UART rx edges, multiplies (signed/unsigned), returns product LS-byte first.
// result_valid W+2 cycles after the last rx edge; each tx byte waits for tx_ready, then TX_GAP idle cycles.
module uart_mul_engine
  import mul_uart_pkg::*;
#(
  parameter int OP_BYTES   = 1,
  parameter int TX_GAP     = 100000,
  parameter int RX_TIMEOUT = 5000000,
  parameter int SIGNED_EN  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mul_enable,
  input  logic                signed_mode,
  uart_mul_engine_if.master   uart,
  output logic                busy,
  output logic                frames_received,
  output logic                result_valid,
  output logic                rx_timeout_err
);
  localparam int W  = UART_BYTE_W * OP_BYTES;
  localparam int NB = byte_count(OP_BYTES);
  localparam int KW = cnt_width(NB);
  localparam int TW = cnt_width(RX_TIMEOUT);
  localparam int GW = cnt_width(TX_GAP);

  state_t         state;
  logic           rx_valid_q;
  logic           rx_evt;
  logic           sign_mode;
  logic           mul_start;
  logic           mul_done;
  logic           tx_acc;
  logic           tx_start_r;
  logic [7:0]     tx_data_r;
  logic [KW-1:0]  k;
  logic [KW-1:0]  j;
  logic [TW-1:0]  to_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [2*W-1:0] opbuf;
  logic [2*W-1:0] product;
  logic [2*W-1:0] p_raw;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic           neg;

  assign rx_evt = uart.rx_valid & ~rx_valid_q;
  assign op_a   = opbuf[W-1:0];
  assign op_b   = opbuf[2*W-1:W];
  // -2^(W-1) negates to itself, which is the correct W-bit unsigned magnitude.
  assign mag_a  = (sign_mode && op_a[W-1]) ? -op_a : op_a;
  assign mag_b  = (sign_mode && op_b[W-1]) ? -op_b : op_b;
  assign neg    = sign_mode & (op_a[W-1] ^ op_b[W-1]);

  assign busy          = (state != ST_IDLE);
  assign uart.tx_start = tx_start_r;
  assign uart.tx_data  = tx_data_r;

  seq_shift_add_mul #(.W(W)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (mag_a),
    .b     (mag_b),
    .done  (mul_done),
    .p     (p_raw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      rx_valid_q      <= 1'b0;
      sign_mode       <= 1'b0;
      mul_start       <= 1'b0;
      tx_acc          <= 1'b0;
      tx_start_r      <= 1'b0;
      tx_data_r       <= '0;
      k               <= '0;
      j               <= '0;
      to_cnt          <= '0;
      gap_cnt         <= '0;
      opbuf           <= '0;
      product         <= '0;
      frames_received <= 1'b0;
      result_valid    <= 1'b0;
      rx_timeout_err  <= 1'b0;
    end else begin
      rx_valid_q     <= uart.rx_valid;
      mul_start      <= 1'b0;
      result_valid   <= 1'b0;
      rx_timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mul_enable) begin
            state     <= ST_RX;
            sign_mode <= signed_mode & (SIGNED_EN != 0);
            k         <= '0;
            to_cnt    <= '0;
          end
        end
        ST_RX: begin
          if (rx_evt) begin
            opbuf[UART_BYTE_W*k +: UART_BYTE_W] <= uart.rx_data;
            to_cnt <= '0;
            if (k == KW'(NB - 1)) begin
              k               <= '0;
              frames_received <= 1'b1;
              mul_start       <= 1'b1;
              state           <= ST_MUL;
            end else begin
              k <= k + KW'(1);
            end
          end else if (k != '0) begin
            // A partial frame is abandoned; the next frame overwrites every byte.
            if (to_cnt == TW'(RX_TIMEOUT - 1)) begin
              rx_timeout_err <= 1'b1;
              k              <= '0;
              to_cnt         <= '0;
              state          <= ST_IDLE;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            product      <= neg ? -p_raw : p_raw;
            result_valid <= 1'b1;
            j            <= '0;
            tx_acc       <= 1'b0;
            state        <= ST_TX;
          end
        end
        ST_TX: begin
          if (!tx_acc) begin
            if (tx_start_r && !uart.tx_ready) begin
              tx_start_r <= 1'b0;
              tx_acc     <= 1'b1;
            end else if (uart.tx_ready) begin
              tx_start_r <= 1'b1;
              tx_data_r  <= product[UART_BYTE_W*j +: UART_BYTE_W];
            end
          end else if (uart.tx_ready) begin
            tx_acc  <= 1'b0;
            gap_cnt <= '0;
            state   <= ST_TX_GAP;
          end
        end
        ST_TX_GAP: begin
          if (gap_cnt == GW'(TX_GAP - 1)) begin
            gap_cnt <= '0;
            if (j == KW'(NB - 1)) begin
              state <= ST_DONE;
            end else begin
              j     <= j + KW'(1);
              state <= ST_TX;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_DONE: begin
          frames_received <= 1'b0;
          j               <= '0;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mul_engine.sv
// Scoreboard bench: two engines (1-byte and 2-byte operands) share rx stimulus; each has a UART tx model.
`timescale 1ns/1ps
module tb_uart_mul_engine;
  localparam int GAP1  = 4;
  localparam int GAP2  = 3;
  localparam int TO    = 50;
  localparam int UBUSY = 3;

  typedef struct {
    logic [7:0] b;
    bit         first;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en1 = 1'b0;
  logic       en2 = 1'b0;
  logic       signed_mode = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy1, fr1, rv1, to1;
  logic       busy2, fr2, rv2, to2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q1[$];
  exp_t exp_q2[$];
  int rv_q1[$];
  int rv_q2[$];
  int to_cnt1 = 0, to_cnt2 = 0;
  int cap_cnt1 = 0, cap_cnt2 = 0;
  int last_cap1 = 0, last_cap2 = 0;
  int bsy1 = 0, bsy2 = 0;

  uart_mul_engine_if if1 ();
  uart_mul_engine_if if2 ();

  assign if1.rx_data  = rx_data;
  assign if1.rx_valid = rx_valid;
  assign if2.rx_data  = rx_data;
  assign if2.rx_valid = rx_valid;

  uart_mul_engine #(.OP_BYTES(1), .TX_GAP(GAP1), .RX_TIMEOUT(TO), .SIGNED_EN(1)) dut1 (
    .clk(clk), .reset(reset), .mul_enable(en1), .signed_mode(signed_mode), .uart(if1),
    .busy(busy1), .frames_received(fr1), .result_valid(rv1), .rx_timeout_err(to1)
  );

  uart_mul_engine #(.OP_BYTES(2), .TX_GAP(GAP2), .RX_TIMEOUT(TO), .SIGNED_EN(1)) dut2 (
    .clk(clk), .reset(reset), .mul_enable(en2), .signed_mode(signed_mode), .uart(if2),
    .busy(busy2), .frames_received(fr2), .result_valid(rv2), .rx_timeout_err(to2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // UART transmitter models: accept on tx_start while idle, then stay busy UBUSY cycles.
  always @(negedge clk) begin : uart1
    exp_t e;
    if (!reset) begin
      if1.tx_ready = 1'b1;
      bsy1 = 0;
    end else if (if1.tx_start && if1.tx_ready) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx1_extra: got byte 0x%0h, expected no byte", if1.tx_data);
      end else begin
        e = exp_q1.pop_front();
        check("tx1_byte", if1.tx_data, e.b);
        if (!e.first) check("tx1_gap", 64'(cyc - last_cap1 >= UBUSY + GAP1), 64'd1);
      end
      last_cap1 = cyc;
      cap_cnt1++;
      if1.tx_ready = 1'b0;
      bsy1 = UBUSY;
    end else if (bsy1 > 0) begin
      bsy1--;
      if (bsy1 == 0) if1.tx_ready = 1'b1;
    end
  end

  always @(negedge clk) begin : uart2
    exp_t e;
    if (!reset) begin
      if2.tx_ready = 1'b1;
      bsy2 = 0;
    end else if (if2.tx_start && if2.tx_ready) begin
      if (exp_q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx2_extra: got byte 0x%0h, expected no byte", if2.tx_data);
      end else begin
        e = exp_q2.pop_front();
        check("tx2_byte", if2.tx_data, e.b);
        if (!e.first) check("tx2_gap", 64'(cyc - last_cap2 >= UBUSY + GAP2), 64'd1);
      end
      last_cap2 = cyc;
      cap_cnt2++;
      if2.tx_ready = 1'b0;
      bsy2 = UBUSY;
    end else if (bsy2 > 0) begin
      bsy2--;
      if (bsy2 == 0) if2.tx_ready = 1'b1;
    end
  end

  // result_valid latency monitor and timeout pulse counters.
  always @(negedge clk) begin
    if (reset) begin
      if (rv1) begin
        if (rv_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rv1_extra: got result_valid at cycle %0d, expected none", cyc);
        end else check("rv1_latency", 64'(cyc), 64'(rv_q1.pop_front()));
      end
      if (rv2) begin
        if (rv_q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL rv2_extra: got result_valid at cycle %0d, expected none", cyc);
        end else check("rv2_latency", 64'(cyc), 64'(rv_q2.pop_front()));
      end
      if (to1) to_cnt1++;
      if (to2) to_cnt2++;
    end
  end

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] v, input int hold);
    rx_data  = v;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input int d, input bit sgn, input logic [63:0] din, input int nb,
                           input logic [63:0] prod, input int hold0, input bit inject);
    int w;
    int t;
    w = (nb / 2) * 8;
    signed_mode = sgn;
    for (int i = 0; i < nb; i++) begin
      if (d == 1) exp_q1.push_back('{b: prod[8*i +: 8], first: (i == 0)});
      else        exp_q2.push_back('{b: prod[8*i +: 8], first: (i == 0)});
    end
    if (d == 1) en1 = 1'b1; else en2 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (i == nb - 1) begin
        if (d == 1) rv_q1.push_back(cyc + 1 + w + 2);
        else        rv_q2.push_back(cyc + 1 + w + 2);
      end
      send_byte(din[8*i +: 8], (i == 0) ? hold0 : 1);
    end
    if (d == 1) en1 = 1'b0; else en2 = 1'b0;
    check("frames_received_set", (d == 1) ? fr1 : fr2, 64'd1);
    check("busy_in_mul", (d == 1) ? busy1 : busy2, 64'd1);
    if (inject) begin
      for (t = 0; t < 200 && !((d == 1) ? if1.tx_start : if2.tx_start); t++) @(negedge clk);
      send_byte(8'hAA, 1);
    end
    for (t = 0; t < 3000; t++) begin
      if (d == 1 && exp_q1.size() == 0 && !busy1) break;
      if (d == 2 && exp_q2.size() == 0 && !busy2) break;
      @(negedge clk);
    end
    if (t >= 3000) begin
      checks++; errors++;
      $display("FAIL frame_done: engine %0d still busy after %0d cycles, expected idle", d, t);
    end
  endtask

  initial begin
    int base;
    int t;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs1", {if1.tx_start, if1.tx_data, busy1, fr1, rv1, to1}, 64'd0);
    check("reset_outs2", {if2.tx_start, if2.tx_data, busy2, fr2, rv2, to2}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1, 1'b0, 64'h110F, 2, 64'h00FF, 1, 1'b0);
    run_frame(1, 1'b1, 64'h02FF, 2, 64'hFFFE, 1, 1'b0);
    run_frame(1, 1'b1, 64'h8080, 2, 64'h4000, 1, 1'b0);

    run_frame(2, 1'b0, 64'hFFFF_FFFF, 4, 64'hFFFE_0001, 1, 1'b0);
    run_frame(2, 1'b1, 64'hFFFF_FFFF, 4, 64'h0000_0001, 1, 1'b0);
    run_frame(2, 1'b1, 64'h0002_8000, 4, 64'hFFFF_0000, 1, 1'b0);

    // Partial frame then silence: one timeout pulse, engine back to idle.
    signed_mode = 1'b0;
    en1 = 1'b1;
    @(negedge clk);
    base = to_cnt1;
    send_byte(8'h55, 1);
    en1 = 1'b0;
    repeat (60) @(negedge clk);
    check("timeout_pulses", 64'(to_cnt1 - base), 64'd1);
    check("timeout_idle", busy1, 64'd0);
    run_frame(1, 1'b0, 64'h0503, 2, 64'h000F, 1, 1'b0);

    // Held rx_valid counts once; a byte injected during TX is ignored.
    run_frame(1, 1'b0, 64'h0907, 2, 64'h003F, 20, 1'b1);

    // Reset while the second product byte is being requested.
    exp_q1.push_back('{b: 8'h2A, first: 1'b1});
    exp_q1.push_back('{b: 8'h00, first: 1'b0});
    en1 = 1'b1;
    @(negedge clk);
    send_byte(8'h06, 1);
    rv_q1.push_back(cyc + 1 + 8 + 2);
    send_byte(8'h07, 1);
    en1 = 1'b0;
    base = cap_cnt1;
    for (t = 0; t < 500 && cap_cnt1 != base + 1; t++) @(negedge clk);
    for (t = 0; t < 500 && !if1.tx_start; t++) begin
      @(posedge clk);
      #1;
    end
    if (!if1.tx_start) begin
      checks++; errors++;
      $display("FAIL second_tx_start: got tx_start 0, expected 1");
    end
    reset = 1'b0;
    #1;
    check("rst_tx_start", if1.tx_start, 64'd0);
    check("rst_busy", busy1, 64'd0);
    check("rst_frames_received", fr1, 64'd0);
    exp_q1.delete();
    rv_q1.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(1, 1'b0, 64'h1010, 2, 64'h0100, 1, 1'b0);

    repeat (5) @(negedge clk);
    check("tx1_queue_drained", 64'(exp_q1.size()), 64'd0);
    check("tx2_queue_drained", 64'(exp_q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
